ascon_ad_absorb: RTL and testbench
==================================

ASCON_AD_ABSORB -- requirements
Module: ascon_ad_absorb

Interface
REQ-001 Parameter RATE, default 64, absorb rate in bits; legal 64 (ASCON-128) or 128 (ASCON-128a).
REQ-002 Parameter PB_ROUNDS, default 6, rounds of p^b per block; legal 6 or 8.
REQ-003 Parameter RPC, default 1, rounds per clock; PB_ROUNDS % RPC != 0 SHALL be an elaboration error.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  begin one AD-absorb operation; sampled only in IDLE.
REQ-007 ad_empty  input  1  qualifies start; no AD blocks follow.
REQ-008 state_in  input  320  initial state {x0,x1,x2,x3,x4}, x0 in [319:256]; sampled with start.
REQ-009 ad_valid  input  1  AD block offered.
REQ-010 ad_ready  output  1  block accepted when ad_valid && ad_ready.
REQ-011 ad_data  input  RATE  pre-padded AD block; for RATE=128 bits [127:64] go to x0, [63:0] to x1.
REQ-012 ad_last  input  1  qualifies ad_data as final block.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse; state_out valid.
REQ-015 state_out  output  320  absorbed state, held from done until next accepted start.

Function
REQ-016 FSM states IDLE, WAIT_AD, PERMUTE, DONE; a single 320-bit state register.
REQ-017 IDLE, start=1, ad_empty=0: load state_in, go WAIT_AD next cycle.
REQ-018 IDLE, start=1, ad_empty=1: load state_in with x4 bit 0 inverted (domain separation), go DONE.
REQ-019 WAIT_AD: ad_ready=1 combinationally; on handshake XOR ad_data into rate words, latch ad_last, clear round counter, go PERMUTE.
REQ-020 WAIT_AD without ad_valid: hold state indefinitely, no timeout.
REQ-021 PERMUTE: each cycle apply RPC consecutive ASCON rounds; round i of p^b uses constant index 12-PB_ROUNDS+i, constant ((15-k)<<4)|k for index k.
REQ-022 PERMUTE lasts exactly PB_ROUNDS/RPC cycles; ad_ready=0 throughout.
REQ-023 On final PERMUTE edge: if latched last=0 go WAIT_AD; if 1, XOR 1 into x4 bit 0 on the same edge, go DONE.
REQ-024 DONE: done=1 for one cycle, then IDLE; start asserted during DONE is ignored.
REQ-025 start asserted outside IDLE SHALL be ignored; ad_valid outside WAIT_AD SHALL not be consumed.
REQ-026 Latency (RPC=1, PB_ROUNDS=6, zero stalls, N blocks): start at cycle 0, done at cycle 7N+1; empty AD: done at cycle 1.

Reset
REQ-027 rst_n low: FSM to IDLE, state register and round counter to 0, ad_ready/busy/done to 0, state_out to 0, asynchronously.
REQ-028 Reset mid-operation SHALL abandon the operation with no done pulse; first start after release behaves as from power-up.

Structure
REQ-029 Package ascon_pkg holds 320-bit state typedef, 5x64 word typedef, round-constant function, S-box and linear-layer rotation constants.
REQ-030 One sub-module ascon_round: combinational single round (constant add, S-box, linear layer); RPC instances chained in ascon_ad_absorb.

Verification
REQ-031 Empty AD, state_in=0, start cycle 0 -> done at cycle 1, state_out x0..x3=0, x4=64'h1.
REQ-032 RATE=64, PB=6, RPC=1, 3 blocks back-to-back after ASCON-128 init state -> done at cycle 22, state_out equals software golden model bit-exact.
REQ-033 Same as REQ-032 with ad_valid low 5 cycles before block 2 -> done at cycle 27, identical state_out.
REQ-034 RATE=128, PB=8, RPC=2, 2 blocks -> PERMUTE 4 cycles per block, done at cycle 11, matches ASCON-128a golden model.
REQ-035 rst_n pulsed low during PERMUTE of block 2 -> no done, outputs 0 immediately; fresh 1-block run then matches model.
REQ-036 start held high through DONE and ad_valid high during PERMUTE -> no second operation started, no extra block absorbed.

Source files
------------

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared ASCON types, round constants, S-box table and linear-layer rotations.
package ascon_pkg;

    typedef logic [319:0] state_t;
    // Word view of the state: x0 sits in the top element, so x_i = w[4-i].
    typedef logic [4:0][63:0] words_t;

    typedef enum logic [1:0] {IDLE, WAIT_AD, PERMUTE, DONE} fsm_t;

    // Indexed by the bit column {x0,x1,x2,x3,x4}, result in the same order.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [7:0] round_const(input int k);
        return 8'(((15 - k) << 4) | k);
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational ASCON round (constant add, S-box, linear diffusion).
module ascon_round
    import ascon_pkg::*;
(
    input  state_t     s_in,
    input  logic [7:0] rc,
    output state_t     s_out
);

    words_t     w_in;
    words_t     w_s;
    words_t     w_out;
    logic [4:0] col;

    always_comb begin
        w_in    = s_in;
        w_in[2] = s_in[191:128] ^ {56'd0, rc};
        w_s     = '0;
        col     = '0;
        for (int b = 0; b < 64; b++) begin
            col = SBOX[{w_in[4][b], w_in[3][b], w_in[2][b], w_in[1][b], w_in[0][b]}];
            for (int i = 0; i < 5; i++) w_s[i][b] = col[i];
        end
        w_out = '0;
        for (int i = 0; i < 5; i++)
            w_out[4-i] = w_s[4-i] ^ ror(w_s[4-i], ROT_A[i]) ^ ror(w_s[4-i], ROT_B[i]);
    end

    assign s_out = w_out;

endmodule

// File: rtl/ascon_ad_absorb.sv
// ascon_ad_absorb: absorbs associated-data blocks into an ASCON state using p^b,
// RPC rounds per clock, and applies the final domain-separation bit.
module ascon_ad_absorb
    import ascon_pkg::*;
#(
    parameter int RATE      = 64,
    parameter int PB_ROUNDS = 6,
    parameter int RPC       = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            ad_empty,
    input  logic [319:0]    state_in,
    input  logic            ad_valid,
    output logic            ad_ready,
    input  logic [RATE-1:0] ad_data,
    input  logic            ad_last,
    output logic            busy,
    output logic            done,
    output logic [319:0]    state_out
);

    localparam int CYCLES = PB_ROUNDS / RPC;

    if (PB_ROUNDS % RPC != 0) begin : g_bad_rpc
        $error("PB_ROUNDS must be a multiple of RPC");
    end
    if (RATE != 64 && RATE != 128) begin : g_bad_rate
        $error("RATE must be 64 or 128");
    end

    fsm_t       fsm_q, fsm_d;
    state_t     st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    state_t     chain [RPC+1];

    assign chain[0] = st_q;

    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [7:0] rc;
        assign rc = round_const(12 - PB_ROUNDS + int'(cnt_q) * RPC + j);
        ascon_round u_round (
            .s_in  (chain[j]),
            .rc    (rc),
            .s_out (chain[j+1])
        );
    end

    always_comb begin
        fsm_d    = fsm_q;
        st_d     = st_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        ad_ready = 1'b0;
        done     = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    st_d  = ad_empty ? state_in ^ 320'd1 : state_in;
                    fsm_d = ad_empty ? DONE : WAIT_AD;
                end
            end
            WAIT_AD: begin
                ad_ready = 1'b1;
                if (ad_valid) begin
                    st_d   = st_q ^ {ad_data, {(320-RATE){1'b0}}};
                    last_d = ad_last;
                    cnt_d  = '0;
                    fsm_d  = PERMUTE;
                end
            end
            PERMUTE: begin
                cnt_d = cnt_q + 4'd1;
                st_d  = chain[RPC];
                if (cnt_q == 4'(CYCLES - 1)) begin
                    st_d  = last_q ? chain[RPC] ^ 320'd1 : chain[RPC];
                    fsm_d = last_q ? DONE : WAIT_AD;
                end
            end
            default: begin
                done  = 1'b1;
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            st_q   <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign busy      = (fsm_q != IDLE);
    assign state_out = st_q;

endmodule

// File: tb/tb_ascon_ad_absorb.sv
// tb_ascon_ad_absorb: directed checks of the AD-absorb block against a bitsliced
// reference permutation for the ASCON-128 and ASCON-128a configurations.
module tb_ascon_ad_absorb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_start, a_empty, a_valid, a_last, a_ready, a_busy, a_done;
    logic [63:0]  a_data;
    logic [319:0] a_init, a_out;
    logic         b_start, b_empty, b_valid, b_last, b_ready, b_busy, b_done;
    logic [127:0] b_data;
    logic [319:0] b_init, b_out;

    ascon_ad_absorb u64 (
        .clk(clk), .rst_n(rst_n), .start(a_start), .ad_empty(a_empty), .state_in(a_init),
        .ad_valid(a_valid), .ad_ready(a_ready), .ad_data(a_data), .ad_last(a_last),
        .busy(a_busy), .done(a_done), .state_out(a_out)
    );

    ascon_ad_absorb #(.RATE(128), .PB_ROUNDS(8), .RPC(2)) u128 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .ad_empty(b_empty), .state_in(b_init),
        .ad_valid(b_valid), .ad_ready(b_ready), .ad_data(b_data), .ad_last(b_last),
        .busy(b_busy), .done(b_done), .state_out(b_out)
    );

    int           errs = 0;
    int           checks = 0;
    int           cyc = 0;
    int           dc;
    logic [127:0] blk [4];
    logic [319:0] res, init64, init128, e1, e2, e3, e128;

    function automatic logic [319:0] m_round(input logic [319:0] s, input int k);
        logic [63:0] x [5];
        logic [63:0] t [5];
        int ra [5] = '{19, 61, 1, 10, 7};
        int rb [5] = '{28, 39, 6, 17, 41};
        for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
        x[2] ^= 64'(((15 - k) << 4) | k);
        x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
        for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i+1)%5];
        for (int i = 0; i < 5; i++) x[i] ^= t[(i+1)%5];
        x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 64; j++)
                t[i][j] = x[i][j] ^ x[i][(j+ra[i])%64] ^ x[i][(j+rb[i])%64];
        return {t[0], t[1], t[2], t[3], t[4]};
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] s, input int pb);
        logic [319:0] r = s;
        for (int i = 0; i < pb; i++) r = m_round(r, 12 - pb + i);
        return r;
    endfunction

    function automatic logic [319:0] m_init(input logic [63:0] iv, input logic [127:0] key, input logic [127:0] nonce);
        return m_perm({iv, key, nonce}, 12) ^ {192'd0, key};
    endfunction

    function automatic logic [319:0] m_absorb(input logic [319:0] init, input int n, input int rate, input int pb);
        logic [319:0] s = init;
        for (int i = 0; i < n; i++) begin
            s ^= (rate == 64) ? {blk[i][63:0], 256'd0} : {blk[i], 192'd0};
            s = m_perm(s, pb);
        end
        return s ^ 320'd1;
    endfunction

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input int sel, input logic st, input logic emp, input logic v,
                         input logic l, input logic [127:0] d, input logic [319:0] init);
        if (sel == 0) begin
            a_start = st; a_empty = emp; a_valid = v; a_last = l; a_data = d[63:0]; a_init = init;
        end else begin
            b_start = st; b_empty = emp; b_valid = v; b_last = l; b_data = d; b_init = init;
        end
    endtask

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? a_ready : b_ready;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? a_done : b_done;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? a_busy : b_busy;
    endfunction

    function automatic logic [319:0] get_out(input int sel);
        return (sel == 0) ? a_out : b_out;
    endfunction

    // Starts one operation at cycle 0 and streams n blocks; stall_at/stall_len hold
    // ad_valid low in WAIT_AD before that block, abort_at pulses reset at that cycle,
    // hold keeps start and ad_valid asserted for the whole operation.
    task automatic run(input int sel, input logic [319:0] init, input int n, input int stall_at,
                       input int stall_len, input int abort_at, input bit hold,
                       output int done_cyc, output logic [319:0] r);
        int   b = 0;
        int   sc = 0;
        int   bi;
        logic v, hs;
        logic st = 1'b1;
        cyc      = 0;
        done_cyc = -1;
        r        = '0;
        for (int k = 0; k < 200; k++) begin
            v  = hold || ((b < n) && !(b == stall_at && sc < stall_len));
            bi = (b < n) ? b : ((n > 0) ? n - 1 : 0);
            drive(sel, st, n == 0, v, b >= n - 1, blk[bi], init);
            hs = v && get_rdy(sel);
            if (get_rdy(sel) && !v && b == stall_at) sc++;
            tick;
            if (!hold) st = 1'b0;
            if (hs) b++;
            if (cyc == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_busy", 320'(get_busy(sel)), 320'd0);
                chk("abort_ready", 320'(get_rdy(sel)), 320'd0);
                chk("abort_done", 320'(get_done(sel)), 320'd0);
                chk("abort_state", get_out(sel), 320'd0);
                return;
            end
            if (get_done(sel)) begin
                done_cyc = cyc;
                r        = get_out(sel);
                break;
            end
        end
    endtask

    task automatic idle_all;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        idle_all;
        blk[0]  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        blk[1]  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        blk[2]  = 128'h5a5a5a5a_a5a5a5a5_41424380_00000000;
        blk[3]  = 128'h0;
        init64  = m_init(64'h80400c0600000000, 128'h000102030405060708090a0b0c0d0e0f,
                         128'h101112131415161718191a1b1c1d1e1f);
        init128 = m_init(64'h80800c0800000000, 128'h000102030405060708090a0b0c0d0e0f,
                         128'h101112131415161718191a1b1c1d1e1f);
        e1   = m_absorb(init64, 1, 64, 6);
        e2   = m_absorb(init64, 2, 64, 6);
        e3   = m_absorb(init64, 3, 64, 6);
        e128 = m_absorb(init128, 2, 128, 8);

        repeat (2) tick;
        chk("rst_busy64", 320'(a_busy), 320'd0);
        chk("rst_done64", 320'(a_done), 320'd0);
        chk("rst_ready64", 320'(a_ready), 320'd0);
        chk("rst_state64", a_out, 320'd0);
        chk("rst_busy128", 320'(b_busy), 320'd0);
        chk("rst_state128", b_out, 320'd0);
        rst_n = 1'b1;
        tick;

        run(0, '0, 0, -1, 0, -1, 1'b0, dc, res);
        chk("empty_cycle", 320'(dc), 320'd1);
        chk("empty_state", res, {256'd0, 64'h1});
        idle_all;
        tick;
        chk("empty_after_done", 320'(a_done), 320'd0);
        chk("empty_after_busy", 320'(a_busy), 320'd0);

        run(0, init64, 3, -1, 0, -1, 1'b0, dc, res);
        chk("blk3_cycle", 320'(dc), 320'd22);
        chk("blk3_state", res, e3);
        idle_all;
        tick;

        run(0, init64, 3, 1, 5, -1, 1'b0, dc, res);
        chk("stall_cycle", 320'(dc), 320'd27);
        chk("stall_state", res, e3);
        idle_all;
        tick;

        run(1, init128, 2, -1, 0, -1, 1'b0, dc, res);
        chk("a128_cycle", 320'(dc), 320'd11);
        chk("a128_state", res, e128);
        idle_all;
        tick;

        run(0, init64, 2, -1, 0, -1, 1'b1, dc, res);
        chk("hold_cycle", 320'(dc), 320'd15);
        chk("hold_state", res, e2);
        tick;
        chk("hold_no_redone", 320'(a_done), 320'd0);
        chk("hold_no_restart", 320'(a_busy), 320'd0);
        idle_all;
        tick;
        chk("hold_idle_busy", 320'(a_busy), 320'd0);
        chk("hold_state_kept", a_out, e2);

        run(0, init64, 3, -1, 0, 10, 1'b0, dc, res);
        chk("abort_no_done", 320'(dc), 320'(-1));
        idle_all;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        run(0, init64, 1, -1, 0, -1, 1'b0, dc, res);
        chk("fresh_cycle", 320'(dc), 320'd8);
        chk("fresh_state", res, e1);
        idle_all;
        tick;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
